// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and helpers for the pipelined carry-lookahead
//                adder/subtractor (operation encoding, lookahead group width,
//                flag payload carried down the skew path, configuration check).
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Operation selected at the input conditioning stage.
    typedef enum logic {
        CLA_ADD = 1'b0,
        CLA_SUB = 1'b1
    } cla_op_e;

    // Width of one carry-lookahead group inside a segment.
    localparam int GROUP_W = 4;

    // Operand sign bits travelling with a beat so the final stage can form
    // the signed-overflow flag.
    typedef struct packed {
        logic a_msb;
        logic b_msb;
    } cla_flag_t;

    // Returns the segment width for a legal (width, stages) pair and 0 for an
    // illegal one: stages must lie in 1..width/GROUP_W and width must split
    // into whole lookahead groups in every segment.
    function automatic int cla_seg_width(input int width, input int stages);
        if ((stages < 1) || (stages > (width / GROUP_W)) ||
            ((width % (GROUP_W * stages)) != 0)) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_segment.sv
`default_nettype none
// ============================================================================
//  Module      : cla_segment
//  Description : Combinational SEG-bit carry-lookahead adder built from 4-bit
//                lookahead groups. Group carries come from a segment-level
//                lookahead over group generate/propagate, so no carry ripples
//                from one group into the next.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_segment
    import cla_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    localparam int c_groups = SEG / GROUP_W;

    logic [SEG-1:0]      w_g;
    logic [SEG-1:0]      w_p;
    logic [c_groups-1:0] w_gg;
    logic [c_groups-1:0] w_gp;
    logic [c_groups:0]   w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    genvar j;
    generate
        for (j = 0; j < c_groups; j++) begin : g_group
            logic [3:0] w_bg;
            logic [3:0] w_bp;
            logic [3:0] w_bc;

            assign w_bg = w_g[j*GROUP_W +: GROUP_W];
            assign w_bp = w_p[j*GROUP_W +: GROUP_W];

            // Bit carries inside the group, each expanded from the group carry-in.
            assign w_bc[0] = w_gc[j];
            assign w_bc[1] = w_bg[0] | (w_bp[0] & w_gc[j]);
            assign w_bc[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_gc[j]);
            assign w_bc[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0]) |
                             (w_bp[2] & w_bp[1] & w_bp[0] & w_gc[j]);

            assign sum[j*GROUP_W +: GROUP_W] = w_bp ^ w_bc;

            assign w_gg[j] = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1]) |
                             (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
            assign w_gp[j] = &w_bp;
        end
    endgenerate

    // Segment-level lookahead: carry into group j is the OR of every lower
    // group generate propagated through the groups above it, plus cin
    // propagated through all of them.
    always_comb begin
        logic acc;
        logic term;
        w_gc    = '0;
        w_gc[0] = cin;
        for (int n = 1; n <= c_groups; n++) begin
            acc = cin;
            for (int m = 0; m < n; m++) begin
                acc = acc & w_gp[m];
            end
            for (int i = 0; i < n; i++) begin
                term = w_gg[i];
                for (int m = i + 1; m < n; m++) begin
                    term = term & w_gp[m];
                end
                acc = acc | term;
            end
            w_gc[n] = acc;
        end
    end

    assign cout = w_gc[c_groups];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined carry-lookahead adder/subtractor. The operands are
//                split into STAGES segments; stage k resolves segment k with
//                the carry registered by stage k-1. Pending operand bits and
//                finished sum bits move down skew registers. Fixed latency of
//                STAGES cycles, one result per cycle, valid/ready handshake
//                with a single pipeline-wide advance.
//  Options     : CLA_PIPE_FLAGS_EN adds registered ovf/zero/neg outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int c_seg = cla_seg_width(WIDTH, STAGES);

    // Per-stage payload. Completed segments are shifted in from the top so
    // segment 0 lands at bit 0 after the last stage; pending operands are
    // shifted down so the next segment to resolve always sits at bit 0.
    typedef struct packed {
        logic [WIDTH-1:0] sum_bits;
        logic             carry;
        logic [WIDTH-1:0] pend_a;
        logic [WIDTH-1:0] pend_b;
`ifdef CLA_PIPE_FLAGS_EN
        cla_flag_t        flags;
`endif
    } stage_t;

    stage_t            r_stage [STAGES];
    stage_t            w_next  [STAGES];
    logic [STAGES-1:0] r_valid;

    cla_op_e           w_op;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic              w_advance;

    // Operand conditioning: subtraction is A + ~B + 1.
    assign w_op      = sub ? CLA_SUB : CLA_ADD;
    assign w_b_eff   = (w_op == CLA_SUB) ? ~b : b;
    assign w_c0      = (w_op == CLA_SUB) ? 1'b1 : cin;

    // Whole pipeline moves together unless a valid result is blocked.
    assign w_advance = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] w_pa;
            logic [WIDTH-1:0] w_pb;
            logic [WIDTH-1:0] w_psum;
            logic             w_cin;
            logic [c_seg-1:0] w_seg_sum;
            logic             w_seg_cout;
            stage_t           w_stage;

            if (k == 0) begin : g_first
                assign w_pa   = a;
                assign w_pb   = w_b_eff;
                assign w_psum = '0;
                assign w_cin  = w_c0;
            end else begin : g_rest
                assign w_pa   = r_stage[k-1].pend_a;
                assign w_pb   = r_stage[k-1].pend_b;
                assign w_psum = r_stage[k-1].sum_bits;
                assign w_cin  = r_stage[k-1].carry;
            end

            cla_segment #(
                .SEG (c_seg)
            ) u_segment (
                .a    (w_pa[c_seg-1:0]),
                .b    (w_pb[c_seg-1:0]),
                .cin  (w_cin),
                .sum  (w_seg_sum),
                .cout (w_seg_cout)
            );

            // Next payload: new segment enters at the top, operands shift down.
            always_comb begin
                w_stage          = '0;
                w_stage.sum_bits = (w_psum >> c_seg) | (WIDTH'(w_seg_sum) << (WIDTH - c_seg));
                w_stage.carry    = w_seg_cout;
                w_stage.pend_a   = w_pa >> c_seg;
                w_stage.pend_b   = w_pb >> c_seg;
`ifdef CLA_PIPE_FLAGS_EN
                if (k == 0) begin
                    w_stage.flags.a_msb = a[WIDTH-1];
                    w_stage.flags.b_msb = w_b_eff[WIDTH-1];
                end else begin
                    w_stage.flags = r_stage[k-1].flags;
                end
`endif
            end

            assign w_next[k] = w_stage;
        end
    endgenerate

    // Stage registers and valid bits; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else if (w_advance) begin
            r_valid <= (r_valid << 1) | STAGES'(in_valid);
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= w_next[s];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_stage[STAGES-1].sum_bits;
    assign cout      = r_stage[STAGES-1].carry;

`ifdef CLA_PIPE_FLAGS_EN
    // Result flags, registered on the same edge as the final sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (w_advance) begin
            ovf  <= (w_next[STAGES-1].flags.a_msb == w_next[STAGES-1].flags.b_msb) &&
                    (w_next[STAGES-1].sum_bits[WIDTH-1] != w_next[STAGES-1].flags.a_msb);
            zero <= (w_next[STAGES-1].sum_bits == '0);
            neg  <= w_next[STAGES-1].sum_bits[WIDTH-1];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder (WIDTH=32, STAGES=4).
//                An arithmetic reference model fills a FIFO of expected
//                results on every accepted beat; a negedge monitor pops and
//                compares on every consumed result. Directed beats pin the
//                model to hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic        ovf;
    logic        zero;
    logic        neg;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    logic        hold_valid = 1'b0;
    logic [32:0] hold_val   = '0;

    cla_pipe_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                   input logic cin_i, input logic sub_i);
        exp_t        r;
        logic [31:0] be;
        logic        c0;
        logic [32:0] full;
        longint      t;
        be     = sub_i ? ~b_i : b_i;
        c0     = sub_i ? 1'b1 : cin_i;
        full   = {1'b0, a_i} + {1'b0, be} + {32'd0, c0};
        r.s    = full[31:0];
        r.c    = full[32];
        t      = longint'($signed(a_i)) + longint'($signed(be)) + longint'(c0);
        r.ovf  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        r.zero = (r.s == 32'd0);
        r.neg  = r.s[31];
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: observes the handshake between edges, for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold_data", {31'd0, cout, sum}, {31'd0, hold_val});
                hold_valid = 1'b0;
            end
            check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (out_valid && !out_ready) begin
                hold_valid = 1'b1;
                hold_val   = {cout, sum};
            end
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("model_sum", {32'd0, sum}, {32'd0, e.s});
                    check("model_cout", {63'd0, cout}, {63'd0, e.c});
`ifdef CLA_PIPE_FLAGS_EN
                    check("model_flags", {61'd0, ovf, zero, neg}, {61'd0, e.ovf, e.zero, e.neg});
`endif
                    got_q.push_back(sum);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
            end
        end
    end

    // One beat into an empty pipeline; checks latency and literal results.
    task automatic send_check(input string nm, input logic [31:0] a_i, input logic [31:0] b_i,
                              input logic cin_i, input logic sub_i, input logic [31:0] es,
                              input logic ec, input logic [2:0] ef);
        exp_t m;
        int   lat;
        m = model(a_i, b_i, cin_i, sub_i);
        check({nm, "_model_sum"}, {32'd0, m.s}, {32'd0, es});
        check({nm, "_model_cout"}, {63'd0, m.c}, {63'd0, ec});
        check({nm, "_model_flags"}, {61'd0, m.ovf, m.zero, m.neg}, {61'd0, ef});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = a_i; b = b_i; cin = cin_i; sub = sub_i;
        lat = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(STAGES));
        check({nm, "_sum"}, {32'd0, sum}, {32'd0, es});
        check({nm, "_cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef CLA_PIPE_FLAGS_EN
        check({nm, "_flags"}, {61'd0, ovf, zero, neg}, {61'd0, ef});
`endif
        @(posedge clk);
        #1;
    endtask

    // Fill the pipe, then pulse reset mid-flight; nothing may come out.
    task automatic reset_midflight(input string nm, input int nbeats, input logic stall);
        int outs_before;
        out_ready = !stall;
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = 32'hA000 + i; b = 32'(i); cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({nm, "_pre_valid"}, {63'd0, out_valid}, {63'd0, stall});
        rst_n = 1'b0;
        #1;
        check({nm, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({nm, "_sum_clear"}, {31'd0, cout, sum}, 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        outs_before = n_out;
        repeat (10) @(posedge clk);
        #1;
        check({nm, "_no_stale_out"}, 64'(n_out), 64'(outs_before));
    endtask

    initial begin
        int idx;
        // Reset held with a valid beat offered.
        in_valid = 1'b1;
        a = 32'h1234_5678; b = 32'h1111_1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid_rel", {63'd0, out_valid}, 64'd0);
        check("reset_sum", {32'd0, sum}, 64'd0);
        check("reset_cout", {63'd0, cout}, 64'd0);

        // Directed beats (flags as {ovf, zero, neg}).
        send_check("carry_all_segs", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'b010);
        send_check("sub_negative",   32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 3'b001);
        send_check("signed_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 3'b101);
        send_check("sub_equal",      32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'b010);
        send_check("sub_ignores_cin", 32'd10,       32'd3,         1'b1, 1'b1, 32'h0000_0007, 1'b1, 3'b000);
        send_check("add_cin",        32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 3'b000);

        // Stream of 8 beats with a 5-cycle output stall.
        got_q.delete();
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            out_ready = !((c >= 6) && (c <= 10));
            in_valid  = (idx < 8);
            a = 32'(idx); b = 32'(idx) * 32'h1000; cin = 1'b0; sub = 1'b0;
            @(negedge clk);
            if (!out_ready && out_valid) begin
                check("stream_stall_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        check("stream_count", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check($sformatf("stream_sum_%0d", i), {32'd0, got_q[i]}, {32'd0, 32'(i) + 32'(i) * 32'h1000});
        end

        // Reset with beats in flight.
        reset_midflight("rst3", 3, 1'b0);
        send_check("after_rst3", 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 3'b000);
        reset_midflight("rst_stalled", STAGES, 1'b1);
        send_check("after_rst_stall", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'b110);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = pick();
            b   = pick();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
